pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period and high time in clock cycles. This is the receive-side counterpart of the generic PWM generator in the utils sector: a line driven by a generator with period T and on-time ton is reported back as period = T and ton = ton. It is used for duty-cycle feedback, RC/servo inputs and loopback checks of PWM outputs. It also flags a stuck line (constant high or low).

---
 rtl/pwm_capture.sv | 181 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with stuck-line detect; optional glitch filter under PWM_CAPTURE_GLITCH_FILTER_EN
module pwm_capture #(
  parameter int MAXT = 4096,
  parameter int FILT = 3,
  localparam int W = $clog2(MAXT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pwm_in,
  output logic [W-1:0] ton,
  output logic [W-1:0] period,
  output logic         valid,
  output logic         stuck,
  output logic         level
);

  if (MAXT < 4 || FILT < 1) begin : g_bad_param
    $error("pwm_capture: MAXT must be >= 4 and FILT >= 1");
  end

  localparam logic [W-1:0] CNT_MAX  = W'(MAXT - 1);
  localparam logic [W-1:0] CNT_WARN = W'(MAXT - 2);
  localparam logic [W-1:0] CNT_ONE  = W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic sync0, sync1, cur, prev;
  logic rise, fall;

  // Everything in the input path resets high so a line already high at release is not a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= pwm_in;
      sync1 <= sync0;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic          filt_q;
  logic [CW-1:0] fcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt   <= '0;
    end else if (sync1 == filt_q) begin
      fcnt <= '0;
    end else if (fcnt == CW'(FILT - 1)) begin
      filt_q <= sync1;
      fcnt   <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign cur = filt_q;
`else
  assign cur = sync1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= cur;
  end

  assign rise  = cur & ~prev;
  assign fall  = ~cur & prev;
  assign level = cur;

  state_t         state, state_nxt;
  logic [W-1:0]   hcnt, hcnt_nxt, pcnt, pcnt_nxt;
  logic [W-1:0]   ton_q, ton_nxt, period_q, period_nxt;
  logic           valid_q, valid_nxt, stuck_q, stuck_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hcnt     <= '0;
      pcnt     <= '0;
      ton_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      hcnt     <= hcnt_nxt;
      pcnt     <= pcnt_nxt;
      ton_q    <= ton_nxt;
      period_q <= period_nxt;
      valid_q  <= valid_nxt;
      stuck_q  <= stuck_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = hcnt;
    pcnt_nxt   = pcnt;
    ton_nxt    = ton_q;
    period_nxt = period_q;
    valid_nxt  = 1'b0;
    stuck_nxt  = stuck_q;

    case (state)
      IDLE: begin
        hcnt_nxt = '0;
        if (rise) begin
          state_nxt = HIGH;
          hcnt_nxt  = CNT_ONE;
          pcnt_nxt  = CNT_ONE;
          stuck_nxt = 1'b0;
        end else begin
          // pcnt doubles as the no-rise watchdog while idle
          if (pcnt != CNT_MAX) pcnt_nxt = pcnt + 1'b1;
          if (pcnt == CNT_WARN) stuck_nxt = 1'b1;
        end
      end

      HIGH: begin
        if (rise) begin
          // A fall went missing; close the period as if it fell this cycle
          ton_nxt    = hcnt;
          period_nxt = pcnt;
          valid_nxt  = 1'b1;
          hcnt_nxt   = CNT_ONE;
          pcnt_nxt   = CNT_ONE;
        end else if (pcnt == CNT_MAX) begin
          state_nxt = IDLE;
          stuck_nxt = 1'b1;
          hcnt_nxt  = '0;
          pcnt_nxt  = '0;
        end else if (fall) begin
          state_nxt = LOW;
          pcnt_nxt  = pcnt + 1'b1;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
          pcnt_nxt = pcnt + 1'b1;
        end
      end

      LOW: begin
        if (rise) begin
          state_nxt  = HIGH;
          ton_nxt    = hcnt;
          period_nxt = pcnt;
          valid_nxt  = 1'b1;
          hcnt_nxt   = CNT_ONE;
          pcnt_nxt   = CNT_ONE;
        end else if (pcnt == CNT_MAX) begin
          state_nxt = IDLE;
          stuck_nxt = 1'b1;
          hcnt_nxt  = '0;
          pcnt_nxt  = '0;
        end else begin
          pcnt_nxt = pcnt + 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        hcnt_nxt  = '0;
        pcnt_nxt  = '0;
      end
    endcase
  end

  assign ton    = ton_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed bench for pwm_capture with an edge-timing reference model
module tb_pwm_capture;
  localparam int MAXT = 128;
  localparam int FILT = 3;
  localparam int W = $clog2(MAXT);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 3 + FILT;
`else
  localparam int LAT = 3;
`endif

  logic clk, rst_n, pwm_in;
  logic [W-1:0] ton, period;
  logic valid, stuck, level;

  pwm_capture #(.MAXT(MAXT), .FILT(FILT)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .ton(ton), .period(period), .valid(valid), .stuck(stuck), .level(level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: works on edge times seen by the measurement logic
  int n, p1, c1, c2, ml, mv, ms, mt, mp, r_at, f_at, base, lnew, curv;
  bit meas, have_f, rise_m, fall_m;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  int fv, lprev;
  int hist[$];
  bit all_diff;
`endif

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      n = 0; p1 = 1; c1 = 1; c2 = 1; ml = 1;
      mv = 0; ms = 0; mt = 0; mp = 0;
      meas = 0; have_f = 0; base = 0; r_at = 0; f_at = 0;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      fv = 1; lprev = 1; hist.delete();
`endif
    end else begin
      n++;
      lnew = p1;
      p1 = int'(pwm_in);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      hist.push_back(lprev);
      if (hist.size() > FILT) void'(hist.pop_front());
      all_diff = (hist.size() == FILT);
      foreach (hist[i]) if (hist[i] == fv) all_diff = 0;
      if (all_diff) begin
        fv = 1 - fv;
        hist.delete();
      end
      lprev = lnew;
      curv = fv;
`else
      curv = lnew;
`endif
      rise_m = (c1 == 1) && (c2 == 0);
      fall_m = (c1 == 0) && (c2 == 1);
      c2 = c1;
      c1 = curv;
      ml = curv;
      mv = 0;
      if (rise_m) begin
        if (meas) begin
          mv = 1;
          mp = n - r_at;
          mt = have_f ? f_at - r_at : n - r_at;
        end
        meas = 1; r_at = n; have_f = 0; ms = 0;
      end else if (meas && (n - r_at == MAXT - 1)) begin
        meas = 0; ms = 1; base = n;
      end else if (!meas && (n - base == MAXT - 1)) begin
        ms = 1;
      end
      if (fall_m && meas && !have_f && !rise_m) begin
        have_f = 1; f_at = n;
      end
    end
  end

  int vcount = 0;
  int last_vcyc = 0;
  int vgap = 0;
  int lastp = 0;
  int lastt = 0;
  int stuck_cyc = 0;
  bit stuck_d = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid", int'(valid), mv);
      chk("stuck", int'(stuck), ms);
      chk("level", int'(level), ml);
      chk("ton", int'(ton), mt);
      chk("period", int'(period), mp);
      if (valid) begin
        vcount++;
        vgap = cyc - last_vcyc;
        last_vcyc = cyc;
        lastp = int'(period);
        lastt = int'(ton);
      end
      if (stuck && !stuck_d) stuck_cyc = cyc;
      stuck_d = stuck;
    end else begin
      stuck_d = 0;
    end
  end

  task automatic drive(input logic v, input int ncyc);
    pwm_in = v;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  task automatic pwm(input int t, input int h, input int np);
    repeat (np) begin
      drive(1'b1, h);
      drive(1'b0, t - h);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ton"}, int'(ton), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_stuck"}, int'(stuck), 0);
    chk({tag, "_level"}, int'(level), 1);
  endtask

  int v0, rise_cyc;

  initial begin
    rst_n = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Line low from reset: idle watchdog, then one clean period
    drive(1'b0, 140);
    chk("idle_stuck", int'(stuck), 1);
    chk("idle_level", int'(level), 0);
    chk("idle_ton", int'(ton), 0);
    chk("idle_period", int'(period), 0);
    chk("idle_nvalid", vcount, 0);
    chk("idle_stuck_at", stuck_cyc - 3, MAXT - 1);
    pwm(100, 25, 3);
    chk("t100_nvalid", vcount, 2);
    chk("t100_period", lastp, 100);
    chk("t100_ton", lastt, 25);
    chk("t100_stuck", int'(stuck), 0);

    // T=50/10 then line forced high
    v0 = vcount;
    pwm(50, 10, 3);
    rise_cyc = cyc;
    drive(1'b1, 140);
    chk("t50_nvalid", vcount - v0, 4);
    chk("t50_latency", last_vcyc - rise_cyc, LAT);
    chk("high_stuck", int'(stuck), 1);
    chk("high_level", int'(level), 1);
    chk("high_ton", int'(ton), 10);
    chk("high_period", int'(period), 50);
    chk("high_stuck_at", stuck_cyc - last_vcyc, MAXT - 1);

    // Async reset mid-period with line high
    drive(1'b0, 10);
    drive(1'b1, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v0 = vcount;
    drive(1'b1, 6);
    chk("rel_nvalid", vcount - v0, 0);
    drive(1'b0, 10);
    pwm(30, 7, 2);
    drive(1'b1, 6);
    chk("rel_nvalid2", vcount - v0, 2);
    chk("rel_period", lastp, 30);
    chk("rel_ton", lastt, 7);

    // 2-cycle glitches in the low phase of T=40/8
    drive(1'b0, 10);
    repeat (3) begin
      drive(1'b1, 8);
      drive(1'b0, 10);
      drive(1'b1, 2);
      drive(1'b0, 20);
    end
    drive(1'b1, 6);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    chk("glitch_period", lastp, 40);
    chk("glitch_ton", lastt, 8);
`else
    chk("glitch_period", lastp, 22);
    chk("glitch_ton", lastt, 2);

    // Minimum waveform T=2/1
    drive(1'b0, 4);
    v0 = vcount;
    pwm(2, 1, 10);
    drive(1'b1, 6);
    chk("t2_nvalid", vcount - v0, 11);
    chk("t2_period", lastp, 2);
    chk("t2_ton", lastt, 1);
    chk("t2_gap", vgap, 2);
`endif

    drive(1'b0, 5);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
